spike_step_scheduler: RTL and testbench

SPIKE_STEP_SCHEDULER -- requirements
Module: spike_step_scheduler

---
 rtl/spike_step_scheduler.sv | 167 ++++++++++++++++
 tb/tb_spike_step_scheduler.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_step_scheduler.sv
// spike_step_scheduler
//   Buffers spike packets in a small FIFO, serializes each packet MSB flit
//   first into a router input port, and generates the neuron-core time-step
//   start pulse. A step boundary is withheld until all pending spike traffic
//   has drained, so a step never starts with spikes still in flight.
//
// Ports
//   rt_clk        sole clock, rising edge
//   rt_reset      synchronous active-high reset
//   enable        1 = time-step timer runs
//   pkt_in        spike packet to inject
//   pkt_valid     pkt_in valid
//   pkt_ready     FIFO can accept a packet this cycle
//   flit_out      flit to router (0 when write_en_out = 0)
//   write_en_out  flit_out valid, router writes it
//   neighbor_full router input FIFO full (stalls the serializer)
//   start_out     one-cycle time-step start pulse
//   step_count    completed time steps (wraps)
//   busy          FIFO non-empty or serializer not idle
//   fifo_count    packets held in the FIFO
module spike_step_scheduler #(
  parameter int PACKET_SIZE = 32,
  parameter int FLIT_SIZE   = 4,
  parameter int FIFO_DEPTH  = 4,   // power of 2, at least 2
  parameter int STEP_CYCLES = 100  // at least 2
) (
  input  logic                          rt_clk,
  input  logic                          rt_reset,
  input  logic                          enable,
  input  logic [PACKET_SIZE-1:0]        pkt_in,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  output logic [FLIT_SIZE-1:0]          flit_out,
  output logic                          write_en_out,
  input  logic                          neighbor_full,
  output logic                          start_out,
  output logic [15:0]                   step_count,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int FLITS = PACKET_SIZE / FLIT_SIZE;
  localparam int IW    = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int TW    = $clog2(STEP_CYCLES);

  localparam logic [IW-1:0] LAST_IDX = IW'(FLITS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TERM     = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t                 state;
  logic [PACKET_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [PACKET_SIZE-1:0] shreg;
  logic [IW-1:0]          idx;
  logic [TW-1:0]          timer;
  logic [15:0]            steps;

  logic pop;
  logic push;
  logic flit_sent;
  logic drained;
  logic at_term;
  logic fire;

  always_comb begin
    // GAP may pop directly so back-to-back packets are spaced by exactly
    // one idle flit slot rather than two.
    pop          = (state == IDLE || state == GAP) && (count != '0);
    // A full FIFO still accepts when the serializer frees a slot this cycle.
    pkt_ready    = !rt_reset && ((count != DEPTH_C) || pop);
    push         = pkt_valid && pkt_ready;
    flit_sent    = (state == SEND) && !neighbor_full;
    write_en_out = !rt_reset && flit_sent;
    flit_out     = write_en_out ? shreg[PACKET_SIZE-1 -: FLIT_SIZE] : '0;
    drained      = (count == '0) && (state == IDLE);
    at_term      = (timer == TERM);
    // drained implies IDLE, so the pulse can never coincide with a flit write.
    fire         = !rt_reset && enable && at_term && drained;
    start_out    = fire;
    busy         = !rt_reset && !drained;
    fifo_count   = rt_reset ? '0 : count;
    step_count   = steps;
  end

  // Packet storage carries no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge rt_clk) begin
    if (push) begin
      mem[wr_ptr] <= pkt_in;
    end
  end

  always_ff @(posedge rt_clk) begin
    if (rt_reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      shreg  <= '0;
      idx    <= '0;
      timer  <= '0;
      steps  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            shreg <= mem[rd_ptr];
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (flit_sent) begin
            shreg <= shreg << FLIT_SIZE;
            if (idx == LAST_IDX) begin
              state <= GAP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        GAP: begin
          if (pop) begin
            shreg <= mem[rd_ptr];
            idx   <= '0;
            state <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Timer parks at terminal count until traffic drains, then wraps.
      if (enable) begin
        if (!at_term) begin
          timer <= timer + 1'b1;
        end else if (drained) begin
          timer <= '0;
          steps <= steps + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_step_scheduler.sv
// tb_spike_step_scheduler
//   Directed bench for spike_step_scheduler with default parameters.
//   Inputs change 1 time unit after a rising edge; outputs are sampled 4
//   units after the edge, before the falling edge.
module tb_spike_step_scheduler;

  logic        rt_clk = 1'b0;
  logic        rt_reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] pkt_in = '0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [3:0]  flit_out;
  logic        write_en_out;
  logic        neighbor_full = 1'b0;
  logic        start_out;
  logic [15:0] step_count;
  logic        busy;
  logic [2:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;

  // Hand-decoded flit sequences (MSB nibble first).
  logic [3:0]  flits_0001 [8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0]  flits_a5c3 [5] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h0};
  logic [31:0] pkts [6] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C,
                            32'hA5A5_5A5A, 32'hFEDC_BA98, 32'h1357_9BDF};

  spike_step_scheduler #(
    .PACKET_SIZE(32),
    .FLIT_SIZE(4),
    .FIFO_DEPTH(4),
    .STEP_CYCLES(100)
  ) dut (
    .rt_clk(rt_clk),
    .rt_reset(rt_reset),
    .enable(enable),
    .pkt_in(pkt_in),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .flit_out(flit_out),
    .write_en_out(write_en_out),
    .neighbor_full(neighbor_full),
    .start_out(start_out),
    .step_count(step_count),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 rt_clk = ~rt_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge rt_clk);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic reset_dut();
    next_cycle();
    rt_reset = 1'b1; pkt_valid = 1'b0; neighbor_full = 1'b0; enable = 1'b0;
    next_cycle();
    next_cycle();
    rt_reset = 1'b0;
    sample();
  endtask

  task automatic test_reset();
    next_cycle();
    rt_reset = 1'b1; pkt_valid = 1'b1; pkt_in = 32'hFFFF_FFFF; enable = 1'b1;
    sample();
    vectors++;
    if ({write_en_out, flit_out, start_out, busy, fifo_count, pkt_ready} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_in1: got %b expected %b",
               {write_en_out, flit_out, start_out, busy, fifo_count, pkt_ready}, 11'b0);
    end
    next_cycle();
    sample();
    vectors++;
    if ({write_en_out, flit_out, start_out, busy, fifo_count, pkt_ready} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_in2: got %b expected %b",
               {write_en_out, flit_out, start_out, busy, fifo_count, pkt_ready}, 11'b0);
    end
    next_cycle();
    rt_reset = 1'b0; pkt_valid = 1'b0; enable = 1'b0;
    sample();
    vectors++;
    if ({write_en_out, flit_out, start_out, busy, fifo_count, pkt_ready} !== 11'b000000_00001) begin
      miscompares++;
      $display("FAIL reset_after: got %b expected %b",
               {write_en_out, flit_out, start_out, busy, fifo_count, pkt_ready}, 11'b1);
    end
    vectors++;
    if (step_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_steps: got %0d expected 0", step_count);
    end
  endtask

  task automatic test_single_packet();
    reset_dut();
    next_cycle();
    pkt_in = 32'h0001_0000; pkt_valid = 1'b1;
    sample();
    vectors++;
    if (pkt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 1", pkt_ready);
    end
    next_cycle();
    pkt_valid = 1'b0;
    sample();
    vectors++;
    if ({write_en_out, fifo_count, busy} !== {1'b0, 3'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_pop: got %b expected %b", {write_en_out, fifo_count, busy}, 5'b00011);
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      sample();
      vectors++;
      if ({write_en_out, flit_out} !== {1'b1, flits_0001[i]}) begin
        miscompares++;
        $display("FAIL single_flit%0d: got we=%b flit=%h expected we=1 flit=%h",
                 i, write_en_out, flit_out, flits_0001[i]);
      end
    end
    next_cycle();
    sample();
    vectors++;
    if ({write_en_out, flit_out, busy} !== 6'b000001) begin
      miscompares++;
      $display("FAIL single_gap: got %b expected %b", {write_en_out, flit_out, busy}, 6'b000001);
    end
    next_cycle();
    sample();
    vectors++;
    if ({write_en_out, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_idle: got %b expected 00", {write_en_out, busy});
    end
  endtask

  task automatic test_stall();
    int k;
    int c;
    int writes;
    reset_dut();
    next_cycle();
    pkt_in = 32'h0001_0000; pkt_valid = 1'b1;
    sample();
    next_cycle();
    pkt_valid = 1'b0;
    sample();
    k = 0; c = 0; writes = 0;
    // Flits 0..2 go out, then the router is full for 3 cycles.
    while (k < 8 && c < 20) begin
      next_cycle();
      neighbor_full = (c >= 3 && c < 6);
      sample();
      if (write_en_out === 1'b1) writes++;
      vectors++;
      if (neighbor_full) begin
        if ({write_en_out, flit_out} !== 5'b0) begin
          miscompares++;
          $display("FAIL stall_c%0d: got we=%b flit=%h expected we=0 flit=0", c, write_en_out, flit_out);
        end
      end else begin
        if ({write_en_out, flit_out} !== {1'b1, flits_0001[k]}) begin
          miscompares++;
          $display("FAIL stall_flit%0d: got we=%b flit=%h expected we=1 flit=%h",
                   k, write_en_out, flit_out, flits_0001[k]);
        end
        k++;
      end
      c++;
    end
    next_cycle();
    neighbor_full = 1'b0;
    sample();
    if (write_en_out === 1'b1) writes++;
    vectors++;
    if (writes !== 8) begin
      miscompares++;
      $display("FAIL stall_writes: got %0d expected 8", writes);
    end
  endtask

  task automatic test_back_to_back();
    int first_cycle [6];
    logic [31:0] got [6];
    logic [31:0] cur;
    int nflits;
    int pk;
    int cyc;
    logic accepted5;
    reset_dut();
    next_cycle();
    neighbor_full = 1'b1; pkt_in = pkts[0]; pkt_valid = 1'b1;
    sample();
    next_cycle();
    pkt_valid = 1'b0;
    sample();
    for (int i = 1; i < 5; i++) begin
      next_cycle();
      pkt_in = pkts[i]; pkt_valid = 1'b1;
      sample();
      vectors++;
      if (pkt_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_ready%0d: got %b expected 1", i, pkt_ready);
      end
    end
    for (int j = 0; j < 3; j++) begin
      next_cycle();
      pkt_in = pkts[5]; pkt_valid = 1'b1;
      sample();
      vectors++;
      if ({pkt_ready, fifo_count, write_en_out} !== {1'b0, 3'd4, 1'b0}) begin
        miscompares++;
        $display("FAIL full_wait%0d: got %b expected %b", j,
                 {pkt_ready, fifo_count, write_en_out}, 5'b01000);
      end
    end
    nflits = 0; pk = 0; cyc = 0; cur = '0; accepted5 = 1'b0;
    while (pk < 6 && cyc < 120) begin
      next_cycle();
      neighbor_full = 1'b0;
      pkt_valid = !accepted5;
      sample();
      if (pkt_valid && pkt_ready) accepted5 = 1'b1;
      if (write_en_out === 1'b1) begin
        if (nflits % 8 == 0) first_cycle[pk] = cyc;
        cur = {cur[27:0], flit_out};
        nflits++;
        if (nflits % 8 == 0) begin
          got[pk] = cur;
          pk++;
        end
      end
      cyc++;
    end
    pkt_valid = 1'b0;
    vectors++;
    if (pk !== 6 || accepted5 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_count: got packets=%0d accepted5=%b expected 6 and 1", pk, accepted5);
    end
    for (int i = 0; i < pk; i++) begin
      vectors++;
      if (got[i] !== pkts[i]) begin
        miscompares++;
        $display("FAIL b2b_pkt%0d: got %h expected %h", i, got[i], pkts[i]);
      end
      if (i > 0) begin
        vectors++;
        if (first_cycle[i] - first_cycle[i-1] !== 9) begin
          miscompares++;
          $display("FAIL b2b_space%0d: got %0d expected 9", i, first_cycle[i] - first_cycle[i-1]);
        end
      end
    end
  endtask

  task automatic test_step_timer();
    int npulses;
    reset_dut();
    npulses = 0;
    for (int t = 0; t < 300; t++) begin
      next_cycle();
      enable = 1'b1;
      sample();
      if (t > 0 && t % 100 == 0) begin
        vectors++;
        if (step_count !== 16'(t / 100)) begin
          miscompares++;
          $display("FAIL steps_t%0d: got %0d expected %0d", t, step_count, t / 100);
        end
      end
      if (start_out === 1'b1) begin
        vectors++;
        if (t !== 99 + 100 * npulses) begin
          miscompares++;
          $display("FAIL pulse%0d_time: got %0d expected %0d", npulses, t, 99 + 100 * npulses);
        end
        npulses++;
      end
    end
    next_cycle();
    enable = 1'b0;
    sample();
    vectors++;
    if (npulses !== 3 || step_count !== 16'd3) begin
      miscompares++;
      $display("FAIL timer_total: got pulses=%0d steps=%0d expected 3 and 3", npulses, step_count);
    end
  endtask

  task automatic test_deferred_start();
    int pulses [$];
    int clash;
    reset_dut();
    clash = 0;
    for (int t = 0; t < 230; t++) begin
      next_cycle();
      enable = 1'b1;
      pkt_valid = (t == 95 || t == 100);
      pkt_in = (t == 95) ? 32'h0001_0000 : 32'hC0DE_1234;
      sample();
      if (t == 100) begin
        vectors++;
        if (pkt_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL defer_accept: got %b expected 1", pkt_ready);
        end
      end
      if (start_out === 1'b1) pulses.push_back(t);
      if (start_out === 1'b1 && write_en_out === 1'b1) clash++;
    end
    next_cycle();
    enable = 1'b0; pkt_valid = 1'b0;
    sample();
    vectors++;
    if (pulses.size() !== 2) begin
      miscompares++;
      $display("FAIL defer_npulses: got %0d expected 2", pulses.size());
    end else begin
      vectors++;
      if (pulses[0] !== 115) begin
        miscompares++;
        $display("FAIL defer_pulse0: got %0d expected 115", pulses[0]);
      end
      vectors++;
      if (pulses[1] !== 215) begin
        miscompares++;
        $display("FAIL defer_pulse1: got %0d expected 215", pulses[1]);
      end
    end
    vectors++;
    if (clash !== 0 || step_count !== 16'd2) begin
      miscompares++;
      $display("FAIL defer_state: got clash=%0d steps=%0d expected 0 and 2", clash, step_count);
    end
  endtask

  task automatic test_reset_mid_packet();
    int writes;
    reset_dut();
    next_cycle();
    pkt_in = 32'hA5C3_0F96; pkt_valid = 1'b1;
    sample();
    next_cycle();
    pkt_in = 32'h7777_7777; pkt_valid = 1'b1;
    sample();
    next_cycle();
    pkt_valid = 1'b0;
    // Flit 0 is on the port this cycle.
    sample();
    vectors++;
    if ({write_en_out, flit_out} !== {1'b1, flits_a5c3[0]}) begin
      miscompares++;
      $display("FAIL mid_flit0: got we=%b flit=%h expected we=1 flit=%h",
               write_en_out, flit_out, flits_a5c3[0]);
    end
    for (int i = 1; i < 5; i++) begin
      next_cycle();
      sample();
      vectors++;
      if ({write_en_out, flit_out} !== {1'b1, flits_a5c3[i]}) begin
        miscompares++;
        $display("FAIL mid_flit%0d: got we=%b flit=%h expected we=1 flit=%h",
                 i, write_en_out, flit_out, flits_a5c3[i]);
      end
    end
    next_cycle();
    rt_reset = 1'b1;
    sample();
    vectors++;
    if ({write_en_out, flit_out, start_out, busy, fifo_count, pkt_ready} !== 11'b0) begin
      miscompares++;
      $display("FAIL mid_in_reset: got %b expected %b",
               {write_en_out, flit_out, start_out, busy, fifo_count, pkt_ready}, 11'b0);
    end
    next_cycle();
    rt_reset = 1'b0;
    sample();
    vectors++;
    if ({write_en_out, busy, fifo_count, pkt_ready} !== 6'b000001) begin
      miscompares++;
      $display("FAIL mid_release: got %b expected %b", {write_en_out, busy, fifo_count, pkt_ready}, 6'b000001);
    end
    writes = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      sample();
      if (write_en_out !== 1'b0) writes++;
    end
    vectors++;
    if (writes !== 0 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_residual: got writes=%0d count=%0d expected 0 and 0", writes, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_stall();
    test_back_to_back();
    test_step_timer();
    test_deferred_start();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
